// File: rtl/ace_snoop_pkg.sv
// Shared definitions for the ACE snoop initiator: FSM state codes, ACSNOOP
// encodings and CRRESP bit positions.
package ace_snoop_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StAc   = 3'd1;
  localparam state_t StCr   = 3'd2;
  localparam state_t StCd   = 3'd3;
  localparam state_t StRsp  = 3'd4;

  localparam logic [3:0] SnpReadOnce          = 4'd0;
  localparam logic [3:0] SnpReadShared        = 4'd1;
  localparam logic [3:0] SnpReadClean         = 4'd2;
  localparam logic [3:0] SnpReadNotSharedDirty = 4'd3;
  localparam logic [3:0] SnpReadUnique        = 4'd7;
  localparam logic [3:0] SnpCleanShared       = 4'd8;
  localparam logic [3:0] SnpCleanInvalid      = 4'd9;
  localparam logic [3:0] SnpMakeInvalid       = 4'd13;

  localparam int unsigned RespDataTransfer = 0;
  localparam int unsigned RespError        = 1;
  localparam int unsigned RespPassDirty    = 2;
  localparam int unsigned RespIsShared     = 3;
  localparam int unsigned RespWasUnique    = 4;

endpackage

// File: rtl/ace_snoop_line_buffer.sv
// Beat counter and cache-line assembly for snoop data arriving on the CD channel.
module ace_snoop_line_buffer
  import ace_snoop_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     last_beat,
  output logic [DATA_W*BEATS-1:0]  line
);

  localparam int unsigned IdxW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BEATS - 1);

  logic [IdxW-1:0] idx_q;

  assign last_beat = (idx_q == LastIdx);

  // Index saturates on the final beat so a stray write can never wrap to beat 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_q <= '0;
    end else if (wr_en && !last_beat) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // The line is only cleared by reset; a new snoop overwrites beats as they arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (idx_q == IdxW'(b)) begin
          line[b*DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/ace_snoop_initiator.sv
// ACE snoop initiator: issues one snoop on AC, collects the CR response and
// optional CD data, and presents the result on the rsp_* handshake.
module ace_snoop_initiator
  import ace_snoop_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned SNOOP_DATA_WIDTH = 128,
  parameter int unsigned CACHE_LINE_SIZE  = 6,
  parameter int unsigned CR_TIMEOUT       = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [3:0]                        req_snoop,
  input  logic [2:0]                        req_prot,
  output logic                              ACVALID,
  input  logic                              ACREADY,
  output logic [ADDR_WIDTH-1:0]             ACADDR,
  output logic [3:0]                        ACSNOOP,
  output logic [2:0]                        ACPROT,
  input  logic                              CRVALID,
  output logic                              CRREADY,
  input  logic [4:0]                        CRRESP,
  input  logic                              CDVALID,
  output logic                              CDREADY,
  input  logic [SNOOP_DATA_WIDTH-1:0]       CDDATA,
  input  logic                              CDLAST,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [4:0]                        rsp_resp,
  output logic [(8 << CACHE_LINE_SIZE)-1:0] rsp_line,
  output logic                              rsp_has_data,
  output logic                              rsp_last_err,
  output logic                              rsp_timeout
);

  localparam int unsigned LineW = 8 << CACHE_LINE_SIZE;
  localparam int unsigned Beats = LineW / SNOOP_DATA_WIDTH;
  localparam int unsigned CntW  = $clog2(CR_TIMEOUT + 1) + 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'((CR_TIMEOUT == 0) ? 0 : CR_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cr_cnt_q;
  logic            req_hs, ac_hs, cr_hs, cd_hs, cd_done, cr_tmo, last_beat;

  assign req_ready = (state_q == StIdle);
  assign CRREADY   = (state_q == StCr);
  assign CDREADY   = (state_q == StCd);
  assign rsp_valid = (state_q == StRsp);

  assign req_hs  = req_valid & req_ready;
  assign ac_hs   = ACVALID & ACREADY & (state_q == StAc);
  assign cr_hs   = CRVALID & CRREADY;
  assign cd_hs   = CDVALID & CDREADY;
  assign cd_done = cd_hs & (CDLAST | last_beat);
  // A CRVALID arriving on the final counted cycle takes priority over the timeout.
  assign cr_tmo  = (CR_TIMEOUT != 0) && (state_q == StCr) && !CRVALID &&
                   (cr_cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_hs) state_d = StAc;
      StAc:   if (ac_hs) state_d = StCr;
      StCr: begin
        if (cr_hs) state_d = CRRESP[RespDataTransfer] ? StCd : StRsp;
        else if (cr_tmo) state_d = StRsp;
      end
      StCd:   if (cd_done) state_d = StRsp;
      StRsp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      ACVALID      <= 1'b0;
      ACADDR       <= '0;
      ACSNOOP      <= '0;
      ACPROT       <= '0;
      cr_cnt_q     <= '0;
      rsp_resp     <= '0;
      rsp_has_data <= 1'b0;
      rsp_last_err <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        ACVALID      <= 1'b1;
        ACADDR       <= req_addr;
        ACSNOOP      <= req_snoop;
        ACPROT       <= req_prot;
        cr_cnt_q     <= '0;
        rsp_last_err <= 1'b0;
        rsp_timeout  <= 1'b0;
      end
      if (ac_hs) begin
        ACVALID <= 1'b0;
      end
      if (state_q == StCr) begin
        cr_cnt_q <= cr_cnt_q + 1'b1;
      end
      if (cr_hs) begin
        rsp_resp     <= CRRESP;
        rsp_has_data <= CRRESP[RespDataTransfer];
      end else if (cr_tmo) begin
        rsp_resp     <= '0;
        rsp_has_data <= 1'b0;
        rsp_timeout  <= 1'b1;
      end
      if (cd_done) begin
        rsp_last_err <= (CDLAST != last_beat);
      end
    end
  end

  ace_snoop_line_buffer #(
    .DATA_W (SNOOP_DATA_WIDTH),
    .BEATS  (Beats)
  ) u_line_buffer (
    .clk       (ACLK),
    .rst       (ARESET),
    .clear     (req_hs),
    .wr_en     (cd_hs),
    .wr_data   (CDDATA),
    .last_beat (last_beat),
    .line      (rsp_line)
  );

endmodule
